ltc2308_spi_responder: RTL and testbench

- Synthesizable SPI responder that emulates the LTC2308 ADC pins (CONVST/SCK/SDI/SDO) so the existing LTC2308 FIFO controller can be exercised in hardware loopback and hardware-in-the-loop setups without a physical converter.
- Oversamples the controller's pins in its own clock domain.
- Times the conversion, shifts 12-bit result data out MSB-first, and captures the 6-bit config word.
- Config takes effect on the next conversion, as in the real part.

---
 rtl/ltc2308_pkg.sv | 30 +++
 rtl/ltc2308_pin_sync.sv | 31 +++
 rtl/ltc2308_spi_responder.sv | 158 +++++++++++++++
 tb/tb_ltc2308_spi_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 SPI responder.
// Holds the FSM state enum, config bit indices and the channel decode helper.
package ltc2308_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    READY,
    SHIFT
  } state_t;

  localparam int DATA_W  = 12;
  localparam int CFG_W   = 6;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

  function automatic logic [2:0] cfg_to_ch(
    input logic [CFG_W-1:0] cfg
  );
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

endpackage

// File: rtl/ltc2308_pin_sync.sv
// Multi-stage synchronizer with registered-history edge detect.
// Ports: clock, reset_n, pin in; level, rise, fall out (rise/fall one cycle).
module ltc2308_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/ltc2308_spi_responder.sv
// LTC2308 pin emulator: times conversions, shifts 12-bit results out on SDO,
// captures the 6-bit config from SDI. Ports: clock, reset_n, adc_convst_i,
// adc_sck_i, adc_sdi_i, adc_sdo_o, sample_ch, sample_data, cfg_word, busy,
// frame_done. LTC2308_RESP_PATTERN_EN swaps sample_data for channel counters.
module ltc2308_spi_responder
  import ltc2308_pkg::*;
#(
  parameter int CONV_CYCLES = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              adc_convst_i,
  input  logic              adc_sck_i,
  input  logic              adc_sdi_i,
  output logic              adc_sdo_o,
  output logic [2:0]        sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  output logic [CFG_W-1:0]  cfg_word,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = $clog2(CONV_CYCLES + 1);

  logic cv_lvl, cv_rise, cv_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  ltc2308_pin_sync #(.STAGES(SYNC_STAGES)) u_cv (
    .clock(clock), .reset_n(reset_n), .pin(adc_convst_i),
    .level(cv_lvl), .rise(cv_rise), .fall(cv_fall)
  );

  ltc2308_pin_sync #(.STAGES(SYNC_STAGES)) u_sck (
    .clock(clock), .reset_n(reset_n), .pin(adc_sck_i),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  ltc2308_pin_sync #(.STAGES(SYNC_STAGES)) u_sdi (
    .clock(clock), .reset_n(reset_n), .pin(adc_sdi_i),
    .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );

  state_t            state;
  logic [CW-1:0]     conv_cnt;
  logic [3:0]        bit_cnt;
  logic [2:0]        rise_cnt;
  logic [CFG_W-1:0]  cfg_sr;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] next_result;
  logic              conv_start;

  // Abort in SHIFT restarts exactly like a fresh start from IDLE.
  assign conv_start = cv_rise &&
                      (state == IDLE || state == SHIFT);

`ifdef LTC2308_RESP_PATTERN_EN
  logic [8:0] pat_cnt [8];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) pat_cnt[i] <= '0;
    end else if (conv_start) begin
      pat_cnt[sample_ch] <= pat_cnt[sample_ch] + 9'd1;
    end
  end

  assign src = {sample_ch, pat_cnt[sample_ch]};
`else
  assign src = sample_data;
`endif

  // Offset binary flips to two's complement in bipolar mode.
  always_comb begin
    next_result = cfg_word[CFG_SLP] ? '0 : src;
    if (!cfg_word[CFG_UNI])
      next_result = next_result ^ 12'h800;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      conv_cnt   <= '0;
      bit_cnt    <= '0;
      rise_cnt   <= '0;
      cfg_sr     <= '0;
      result     <= '0;
      adc_sdo_o  <= 1'b0;
      sample_ch  <= 3'd0;
      cfg_word   <= CFG_RESET;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (conv_start) begin
        state     <= CONVERT;
        conv_cnt  <= CW'(CONV_CYCLES - 1);
        result    <= next_result;
        busy      <= 1'b1;
        adc_sdo_o <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          CONVERT: begin
            if (conv_cnt == '0) begin
              busy <= 1'b0;
              // A short CONVST pulse skips READY.
              if (cv_lvl) begin
                state <= READY;
              end else begin
                state     <= SHIFT;
                adc_sdo_o <= result[DATA_W-1];
                bit_cnt   <= '0;
                rise_cnt  <= '0;
                cfg_sr    <= '0;
              end
            end else begin
              conv_cnt <= conv_cnt - 1'b1;
            end
          end
          READY: begin
            if (!cv_lvl) begin
              state     <= SHIFT;
              adc_sdo_o <= result[DATA_W-1];
              bit_cnt   <= '0;
              rise_cnt  <= '0;
              cfg_sr    <= '0;
            end
          end
          SHIFT: begin
            if (sck_rise && rise_cnt < 3'd6) begin
              cfg_sr   <= {cfg_sr[CFG_W-2:0], sdi_lvl};
              rise_cnt <= rise_cnt + 3'd1;
            end
            if (sck_fall) begin
              if (bit_cnt == 4'd11) begin
                state      <= IDLE;
                adc_sdo_o  <= 1'b0;
                frame_done <= 1'b1;
                if (rise_cnt == 3'd6) begin
                  cfg_word  <= cfg_sr;
                  sample_ch <= cfg_to_ch(cfg_sr);
                end
              end else begin
                bit_cnt   <= bit_cnt + 4'd1;
                adc_sdo_o <= result[4'd10 - bit_cnt];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ltc2308_spi_responder.sv
// Scoreboard bench for ltc2308_spi_responder.
// Driver pushes expected words; SCK-rise monitor pops and compares.
`timescale 1ns/1ps
module tb_ltc2308_spi_responder;
  import ltc2308_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        adc_convst_i = 1'b0;
  logic        adc_sck_i = 1'b0;
  logic        adc_sdi_i = 1'b0;
  logic        adc_sdo_o;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data = 12'h000;
  logic [5:0]  cfg_word;
  logic        busy;
  logic        frame_done;

  ltc2308_spi_responder #(.CONV_CYCLES(64), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .adc_convst_i(adc_convst_i), .adc_sck_i(adc_sck_i),
    .adc_sdi_i(adc_sdi_i), .adc_sdo_o(adc_sdo_o),
    .sample_ch(sample_ch), .sample_data(sample_data),
    .cfg_word(cfg_word), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [11:0] exp_q[$];
  logic        frame_en = 1'b0;
  logic [11:0] shreg = '0;
  int          nbits = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  always @(negedge clock)
    if (reset_n && frame_done) done_cnt++;

  always @(posedge adc_convst_i) nbits = 0;

  always @(posedge adc_sck_i) begin
    if (frame_en) begin
      if (nbits < 12) begin
        shreg = {shreg[10:0], adc_sdo_o};
        nbits++;
        if (nbits == 12) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_word got=%h expected=<none>", shreg);
          end else begin
            logic [11:0] e;
            e = exp_q.pop_front();
            if (shreg !== e) begin
              errors++;
              $display("FAIL frame_word got=%h expected=%h", shreg, e);
            end
          end
        end
      end else begin
        checks++;
        if (adc_sdo_o !== 1'b0) begin
          errors++;
          $display("FAIL extra_sdo got=%b expected=0", adc_sdo_o);
        end
      end
    end
  end

  task automatic convert(input int hold);
    @(negedge clock);
    adc_convst_i = 1'b1;
    repeat (hold) @(negedge clock);
    adc_convst_i = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic frame(input logic [5:0] sdi, input int nsck);
    logic [5:0] w;
    w = sdi;
    frame_en = 1'b1;
    for (int i = 0; i < nsck; i++) begin
      adc_sdi_i = (i < 6) ? w[5 - i] : 1'b0;
      repeat (8) @(negedge clock);
      adc_sck_i = 1'b1;
      repeat (8) @(negedge clock);
      adc_sck_i = 1'b0;
    end
    repeat (8) @(negedge clock);
    frame_en = 1'b0;
  endtask

  task automatic full(input logic [11:0] d, input logic [11:0] e,
                      input logic [5:0] sdi);
    sample_data = d;
    exp_q.push_back(e);
    convert(70);
    frame(sdi, 12);
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL timeout got=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int bw;
    int waitc;
    repeat (3) @(negedge clock);
    chk("rst_sdo", adc_sdo_o, 0);
    chk("rst_ch", sample_ch, 0);
    chk("rst_cfg", cfg_word, 6'b100010);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

`ifdef LTC2308_RESP_PATTERN_EN
    full(12'hFFF, 12'h000, 6'b110110);
    chk("pat_ch", sample_ch, 3);
    full(12'hFFF, 12'h600, 6'b110110);
    full(12'h000, 12'h601, 6'b110110);
    full(12'h123, 12'h602, 6'b110110);
    chk("pat_done", done_cnt, 4);
`else
    full(12'hA5C, 12'hA5C, 6'b100010);
    chk("f1_done", done_cnt, 1);
    chk("f1_cfg", cfg_word, 6'b100010);
    full(12'h123, 12'h123, 6'b110010);
    chk("f2_cfg", cfg_word, 6'b110010);
    chk("f2_ch", sample_ch, 1);
    full(12'h3C3, 12'h3C3, 6'b110000);
    chk("f3_cfg", cfg_word, 6'b110000);
    full(12'h000, 12'h800, 6'b110011);
    chk("f4_cfg", cfg_word, 6'b110011);
    full(12'hFFF, 12'h000, 6'b100010);
    chk("f5_cfg", cfg_word, 6'b100010);
    chk("f5_ch", sample_ch, 0);

    // aborted frame after 5 SCK clocks
    sample_data = 12'h555;
    convert(70);
    frame(6'b110000, 5);
    sample_data = 12'h9A6;
    exp_q.push_back(12'h9A6);
    adc_convst_i = 1'b1;
    waitc = 0;
    while (!busy && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    bw = 0;
    while (busy && bw < 200) begin
      @(negedge clock);
      bw++;
    end
    chk("busy_width", bw, 64);
    chk("abort_done", done_cnt, 5);
    chk("abort_cfg", cfg_word, 6'b100010);
    repeat (8) @(negedge clock);
    adc_convst_i = 1'b0;
    repeat (8) @(negedge clock);
    frame(6'b100010, 12);
    chk("f6_done", done_cnt, 6);

    // SCK activity during CONVERT is ignored
    sample_data = 12'h6D9;
    exp_q.push_back(12'h6D9);
    @(negedge clock);
    adc_convst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (8) @(negedge clock);
      adc_sck_i = 1'b1;
      repeat (8) @(negedge clock);
      adc_sck_i = 1'b0;
    end
    repeat (22) @(negedge clock);
    chk("conv_sck_sdo", adc_sdo_o, 0);
    adc_convst_i = 1'b0;
    repeat (8) @(negedge clock);
    frame(6'b100010, 12);

    // short CONVST pulse goes straight to SHIFT
    sample_data = 12'h0F0;
    exp_q.push_back(12'h0F0);
    @(negedge clock);
    adc_convst_i = 1'b1;
    repeat (10) @(negedge clock);
    adc_convst_i = 1'b0;
    repeat (75) @(negedge clock);
    frame(6'b100010, 12);

    // 14 SCK clocks: two extra bits must read 0
    full(12'hFFF, 12'hFFF, 6'b100010);
    sample_data = 12'hC31;
    exp_q.push_back(12'hC31);
    convert(70);
    frame(6'b100010, 14);
    chk("extra_done", done_cnt, 10);
    chk("extra_sdo_lvl", adc_sdo_o, 0);
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
